// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding, flush counter
// width, performance counter width and the load-use detection helper.
package pipeline_hazard_ctrl_pkg;

    localparam int STATE_W = 2;
    localparam int CNT_W   = 2;
    localparam int PERF_W  = 32;

    // Legacy-compatible state constants; RUN is the reset state.
    localparam logic [STATE_W-1:0] ST_RUN     = 2'd0;
    localparam logic [STATE_W-1:0] ST_MD_WAIT = 2'd1;
    localparam logic [STATE_W-1:0] ST_FLUSH   = 2'd2;

    // True when the ID instruction reads a register that a load in EX is
    // about to write. Register 0 is hardwired to zero and never hazards.
    function automatic logic is_load_use(
        input logic       ex_load,
        input logic [4:0] ex_rd,
        input logic       use_rs1,
        input logic [4:0] rs1,
        input logic       use_rs2,
        input logic [4:0] rs2
    );
        return ex_load && (ex_rd != 5'd0) &&
               ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status into the controller, stage
// enables/flushes, performance counters and the FSM state out of it.
interface pipeline_hazard_ctrl_if;
    import pipeline_hazard_ctrl_pkg::*;

    logic [4:0]          id_rs1;
    logic [4:0]          id_rs2;
    logic                id_use_rs1;
    logic                id_use_rs2;
    logic                ex_wb_load;
    logic [4:0]          ex_wb_rd;
    logic                ex_mispredict;
    logic                ex_muldiv_start;
    logic                muldiv_done;
    logic                perf_clr;

    logic                pc_en;
    logic                if_id_en;
    logic                id_ex_en;
    logic                if_id_flush;
    logic                id_ex_flush;
    logic                ex_mem_flush;
    logic [PERF_W-1:0]   stall_cycles;
    logic [PERF_W-1:0]   flush_cycles;
    logic [STATE_W-1:0]  dbg_state;

    // Pipeline side: drives status, consumes control.
    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_wb_load, ex_wb_rd,
               ex_mispredict, ex_muldiv_start, muldiv_done, perf_clr,
        input  pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush,
               ex_mem_flush, stall_cycles, flush_cycles, dbg_state
    );

    // Controller side.
    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_wb_load, ex_wb_rd,
               ex_mispredict, ex_muldiv_start, muldiv_done, perf_clr,
        output pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush,
               ex_mem_flush, stall_cycles, flush_cycles, dbg_state
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_perf_counter_sat.sv
// Saturating event counter: counts cycles with i_inc high, sticks at all
// ones, synchronous clear wins over increment.
module perf_counter_sat
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_inc,
    input  logic              i_clr,
    output logic [PERF_W-1:0] o_count
);

    logic [PERF_W-1:0] r_count;
    logic              w_at_max;

    assign w_at_max = &r_count;
    assign o_count  = r_count;

    // Count events, holding at the maximum instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !w_at_max) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: resolves load-use, multi-cycle mul/div and
// branch mispredict hazards into stage enables and bubble inserts, and
// counts stall and flush cycles.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_hazard_ctrl_if.slave  hz
);

    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;
    logic [CNT_W-1:0]   r_flush_cnt;
    logic [CNT_W-1:0]   w_flush_cnt_nxt;

    logic w_load_use;
    logic w_pc_en;
    logic w_if_id_en;
    logic w_id_ex_en;
    logic w_if_id_flush;
    logic w_id_ex_flush;
    logic w_ex_mem_flush;

    assign w_load_use = is_load_use(hz.ex_wb_load, hz.ex_wb_rd,
                                    hz.id_use_rs1, hz.id_rs1,
                                    hz.id_use_rs2, hz.id_rs2);

    // Next-state and control decode; mispredict beats mul/div beats load-use.
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_pc_en         = 1'b1;
        w_if_id_en      = 1'b1;
        w_id_ex_en      = 1'b1;
        w_if_id_flush   = 1'b0;
        w_id_ex_flush   = 1'b0;
        w_ex_mem_flush  = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (hz.ex_mispredict) begin
                    // PC takes the redirect; squash the wrong-path IF/ID and ID/EX.
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_state_nxt     = ST_FLUSH;
                        w_flush_cnt_nxt = FLUSH_LOAD;
                    end
                end else if (hz.ex_muldiv_start) begin
                    // Freeze the front end; EX/MEM gets bubbles while the unit runs.
                    w_pc_en        = 1'b0;
                    w_if_id_en     = 1'b0;
                    w_id_ex_en     = 1'b0;
                    w_ex_mem_flush = 1'b1;
                    w_state_nxt    = ST_MD_WAIT;
                end else if (w_load_use) begin
                    // Hold IF and ID one cycle, let a bubble into EX.
                    w_pc_en       = 1'b0;
                    w_if_id_en    = 1'b0;
                    w_id_ex_flush = 1'b1;
                end
            end

            ST_MD_WAIT: begin
                if (hz.muldiv_done) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_pc_en        = 1'b0;
                    w_if_id_en     = 1'b0;
                    w_id_ex_en     = 1'b0;
                    w_ex_mem_flush = 1'b1;
                end
            end

            ST_FLUSH: begin
                // EX holds bubbles here, so its hazard inputs are meaningless.
                w_if_id_flush   = 1'b1;
                w_flush_cnt_nxt = r_flush_cnt - 1'b1;
                if (r_flush_cnt <= CNT_W'(1)) begin
                    w_state_nxt     = ST_RUN;
                    w_flush_cnt_nxt = '0;
                end
            end

            default: begin
                w_state_nxt     = ST_RUN;
                w_flush_cnt_nxt = '0;
            end
        endcase

        // Reset shows the free-running default regardless of inputs.
        if (!rst_n) begin
            w_pc_en        = 1'b1;
            w_if_id_en     = 1'b1;
            w_id_ex_en     = 1'b1;
            w_if_id_flush  = 1'b0;
            w_id_ex_flush  = 1'b0;
            w_ex_mem_flush = 1'b0;
        end
    end

    // FSM state and remaining-flush counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    assign hz.pc_en        = w_pc_en;
    assign hz.if_id_en     = w_if_id_en;
    assign hz.id_ex_en     = w_id_ex_en;
    assign hz.if_id_flush  = w_if_id_flush;
    assign hz.id_ex_flush  = w_id_ex_flush;
    assign hz.ex_mem_flush = w_ex_mem_flush;
    assign hz.dbg_state    = r_state;

    perf_counter_sat u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (!w_pc_en),
        .i_clr   (hz.perf_clr),
        .o_count (hz.stall_cycles)
    );

    perf_counter_sat u_flush_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_if_id_flush),
        .i_clr   (hz.perf_clr),
        .o_count (hz.flush_cycles)
    );

endmodule
